// File: rtl/dual_alu_wb.sv
// dual_alu_wb: execute/write-back stage downstream of a 4-read/2-write register file.
// Two ALU lanes per command; MUL lanes share a 1-bit-per-cycle shift-add sequencer.
module dual_alu_wb #(
  parameter int unsigned DATAWIDTH = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           op1,
  input  logic [3:0]           op2,
  input  logic [3:0]           dst1,
  input  logic [3:0]           dst2,
  input  logic [3:0]           srcA1,
  input  logic [3:0]           srcB1,
  input  logic [3:0]           srcA2,
  input  logic [3:0]           srcB2,
  output logic [3:0]           readReg1,
  output logic [3:0]           readReg2,
  output logic [3:0]           readReg3,
  output logic [3:0]           readReg4,
  input  logic [DATAWIDTH-1:0] readData1,
  input  logic [DATAWIDTH-1:0] readData2,
  input  logic [DATAWIDTH-1:0] readData3,
  input  logic [DATAWIDTH-1:0] readData4,
  output logic [3:0]           writeReg1,
  output logic [3:0]           writeReg2,
  output logic [DATAWIDTH-1:0] writeData1,
  output logic [DATAWIDTH-1:0] writeData2,
  output logic                 write,
  output logic                 done,
  output logic                 zero1,
  output logic                 zero2,
  output logic                 ovf1,
  output logic                 ovf2
);
  localparam int unsigned ShW = $clog2(DATAWIDTH);
  localparam int unsigned Dw2 = 2 * DATAWIDTH;
  localparam logic [3:0] OpMul = 4'd11;
  localparam logic [ShW-1:0] CntLast = ShW'(DATAWIDTH - 1);

  typedef enum logic [2:0] {StIdle, StRead, StExec, StMul, StWb} state_e;
  state_e state_q, state_d;

  logic [3:0]           op1_q, op2_q, dst1_q, dst2_q;
  logic [DATAWIDTH-1:0] res1_q, res2_q, mplier1_q, mplier2_q;
  logic                 ovfi1_q, ovfi2_q;
  logic [Dw2-1:0]       acc1_q, acc2_q, mcand1_q, mcand2_q, acc1_d, acc2_d;
  logic [ShW-1:0]       cnt_q;

  logic                 mul1, mul2, any_mul, act1, act2, cnt_last, load_wb;
  logic [DATAWIDTH:0]   alu1, alu2;
  logic [DATAWIDTH-1:0] fin1, fin2;
  logic                 fovf1, fovf2;

  // Returns {signed_overflow, result}.
  function automatic logic [DATAWIDTH:0] alu(input logic [3:0] op,
                                             input logic [DATAWIDTH-1:0] a,
                                             input logic [DATAWIDTH-1:0] b);
    logic [DATAWIDTH-1:0] r;
    logic                 v;
    logic [ShW-1:0]       sh;
    r  = '0;
    v  = 1'b0;
    sh = b[ShW-1:0];
    case (op)
      4'd0: begin
        r = a + b;
        v = (a[DATAWIDTH-1] == b[DATAWIDTH-1]) && (r[DATAWIDTH-1] != a[DATAWIDTH-1]);
      end
      4'd1: begin
        r = a - b;
        v = (a[DATAWIDTH-1] != b[DATAWIDTH-1]) && (r[DATAWIDTH-1] != a[DATAWIDTH-1]);
      end
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = a << sh;
      4'd6:  r = a >> sh;
      4'd7:  r = $signed(a) >>> sh;
      4'd8:  r[0] = $signed(a) < $signed(b);
      4'd9:  r[0] = a < b;
      4'd10: r = a;
      default: ;
    endcase
    return {v, r};
  endfunction

  assign in_ready = (state_q == StIdle);

  always_comb begin
    mul1     = (op1_q == OpMul);
    mul2     = (op2_q == OpMul);
    any_mul  = mul1 | mul2;
    act1     = (op1_q < 4'd12);
    act2     = (op2_q < 4'd12);
    cnt_last = (cnt_q == CntLast);
    alu1     = alu(op1_q, readData1, readData2);
    alu2     = alu(op2_q, readData3, readData4);
    acc1_d   = acc1_q + (mplier1_q[0] ? mcand1_q : '0);
    acc2_d   = acc2_q + (mplier2_q[0] ? mcand2_q : '0);
    if (state_q == StMul) begin
      // Non-MUL lanes keep the result registered in EXEC.
      fin1  = mul1 ? acc1_d[DATAWIDTH-1:0] : res1_q;
      fin2  = mul2 ? acc2_d[DATAWIDTH-1:0] : res2_q;
      fovf1 = mul1 ? |acc1_d[Dw2-1:DATAWIDTH] : ovfi1_q;
      fovf2 = mul2 ? |acc2_d[Dw2-1:DATAWIDTH] : ovfi2_q;
    end else begin
      fin1  = alu1[DATAWIDTH-1:0];
      fin2  = alu2[DATAWIDTH-1:0];
      fovf1 = alu1[DATAWIDTH];
      fovf2 = alu2[DATAWIDTH];
    end
    load_wb = ((state_q == StExec) && !any_mul) || ((state_q == StMul) && cnt_last);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (in_valid) state_d = StRead;
      StRead:  state_d = StExec;
      StExec:  state_d = any_mul ? StMul : StWb;
      StMul:   if (cnt_last) state_d = StWb;
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      op1_q      <= '0;
      op2_q      <= '0;
      dst1_q     <= '0;
      dst2_q     <= '0;
      res1_q     <= '0;
      res2_q     <= '0;
      ovfi1_q    <= 1'b0;
      ovfi2_q    <= 1'b0;
      acc1_q     <= '0;
      acc2_q     <= '0;
      mcand1_q   <= '0;
      mcand2_q   <= '0;
      mplier1_q  <= '0;
      mplier2_q  <= '0;
      cnt_q      <= '0;
      readReg1   <= '0;
      readReg2   <= '0;
      readReg3   <= '0;
      readReg4   <= '0;
      writeReg1  <= '0;
      writeReg2  <= '0;
      writeData1 <= '0;
      writeData2 <= '0;
      write      <= 1'b0;
      done       <= 1'b0;
      zero1      <= 1'b0;
      zero2      <= 1'b0;
      ovf1       <= 1'b0;
      ovf2       <= 1'b0;
    end else begin
      state_q <= state_d;
      write   <= 1'b0;
      done    <= 1'b0;
      case (state_q)
        StIdle: if (in_valid) begin
          op1_q    <= op1;
          op2_q    <= op2;
          dst1_q   <= dst1;
          dst2_q   <= dst2;
          readReg1 <= srcA1;
          readReg2 <= srcB1;
          readReg3 <= srcA2;
          readReg4 <= srcB2;
        end
        StExec: begin
          res1_q    <= alu1[DATAWIDTH-1:0];
          res2_q    <= alu2[DATAWIDTH-1:0];
          ovfi1_q   <= alu1[DATAWIDTH];
          ovfi2_q   <= alu2[DATAWIDTH];
          acc1_q    <= '0;
          acc2_q    <= '0;
          mcand1_q  <= {{DATAWIDTH{1'b0}}, readData1};
          mcand2_q  <= {{DATAWIDTH{1'b0}}, readData3};
          mplier1_q <= readData2;
          mplier2_q <= readData4;
          cnt_q     <= '0;
        end
        StMul: begin
          acc1_q    <= acc1_d;
          acc2_q    <= acc2_d;
          mcand1_q  <= mcand1_q << 1;
          mcand2_q  <= mcand2_q << 1;
          mplier1_q <= mplier1_q >> 1;
          mplier2_q <= mplier2_q >> 1;
          cnt_q     <= cnt_q + 1'b1;
        end
        StWb: begin
          readReg1 <= '0;
          readReg2 <= '0;
          readReg3 <= '0;
          readReg4 <= '0;
        end
        default: ;
      endcase
      if (load_wb) begin
        done  <= 1'b1;
        write <= act1 | act2;
        zero1 <= act1 && (fin1 == '0);
        zero2 <= act2 && (fin2 == '0);
        ovf1  <= act1 && fovf1;
        ovf2  <= act2 && fovf2;
        // Single write strobe: an idle lane mirrors the active one.
        if (act1 && act2) begin
          writeReg1  <= dst1_q;
          writeReg2  <= dst2_q;
          writeData1 <= (dst1_q == dst2_q) ? fin2 : fin1;
          writeData2 <= fin2;
        end else if (act1) begin
          writeReg1  <= dst1_q;
          writeReg2  <= dst1_q;
          writeData1 <= fin1;
          writeData2 <= fin1;
        end else if (act2) begin
          writeReg1  <= dst2_q;
          writeReg2  <= dst2_q;
          writeData1 <= fin2;
          writeData2 <= fin2;
        end
      end
    end
  end

endmodule

// File: tb/tb_dual_alu_wb.sv
// tb_dual_alu_wb: directed bench for dual_alu_wb with a behavioural register file
// (registered reads, two write ports, port 2 wins on a shared address).
module tb_dual_alu_wb;
  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid, in_ready;
  logic [3:0]  op1, op2, dst1, dst2, srcA1, srcB1, srcA2, srcB2;
  logic [3:0]  readReg1, readReg2, readReg3, readReg4;
  logic [31:0] readData1, readData2, readData3, readData4;
  logic [3:0]  writeReg1, writeReg2;
  logic [31:0] writeData1, writeData2;
  logic        write, done, zero1, zero2, ovf1, ovf2;

  logic        pre_en;
  logic [3:0]  pre_addr;
  logic [31:0] pre_data;
  logic [31:0] rf [16];
  logic [31:0] snap [16];
  logic [31:0] init_rf [16];

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  dual_alu_wb #(.DATAWIDTH(32)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op1       (op1),
    .op2       (op2),
    .dst1      (dst1),
    .dst2      (dst2),
    .srcA1     (srcA1),
    .srcB1     (srcB1),
    .srcA2     (srcA2),
    .srcB2     (srcB2),
    .readReg1  (readReg1),
    .readReg2  (readReg2),
    .readReg3  (readReg3),
    .readReg4  (readReg4),
    .readData1 (readData1),
    .readData2 (readData2),
    .readData3 (readData3),
    .readData4 (readData4),
    .writeReg1 (writeReg1),
    .writeReg2 (writeReg2),
    .writeData1(writeData1),
    .writeData2(writeData2),
    .write     (write),
    .done      (done),
    .zero1     (zero1),
    .zero2     (zero2),
    .ovf1      (ovf1),
    .ovf2      (ovf2)
  );

  always @(posedge clk) begin
    readData1 <= rf[readReg1];
    readData2 <= rf[readReg2];
    readData3 <= rf[readReg3];
    readData4 <= rf[readReg4];
    if (pre_en) rf[pre_addr] <= pre_data;
    if (write) begin
      rf[writeReg1] <= writeData1;
      rf[writeReg2] <= writeData2;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rf_diffs();
    int n;
    n = 0;
    for (int i = 0; i < 16; i++) if (rf[i] !== snap[i]) n++;
    return n;
  endfunction

  // cmd = {op1, op2, dst1, dst2, srcA1, srcB1, srcA2, srcB2}; flags = {zero1, zero2, ovf1, ovf2}
  task automatic run(input string tag, input logic [31:0] cmd, input int exp_done,
                     input logic exp_wr, input logic [7:0] ewr, input logic [63:0] ewd,
                     input logic [3:0] eflags);
    int cyc;
    int wr_early;
    int rdy_early;
    cyc       = 0;
    wr_early  = 0;
    rdy_early = 0;
    chk({tag, " idle ready"}, in_ready, 1);
    {op1, op2, dst1, dst2, srcA1, srcB1, srcA2, srcB2} = cmd;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    {op1, op2, dst1, dst2, srcA1, srcB1, srcA2, srcB2} = $urandom();
    cyc = 1;
    chk({tag, " readReg"}, {readReg1, readReg2, readReg3, readReg4}, cmd[15:0]);
    while (done !== 1'b1 && cyc < 100) begin
      if (write !== 1'b0) wr_early++;
      if (in_ready !== 1'b0) rdy_early++;
      @(negedge clk);
      cyc++;
    end
    chk({tag, " done cycle"}, cyc, exp_done);
    chk({tag, " early write"}, wr_early, 0);
    chk({tag, " busy ready"}, rdy_early, 0);
    chk({tag, " wb write/ready"}, {write, in_ready}, {exp_wr, 1'b0});
    if (exp_wr) begin
      chk({tag, " writeReg"}, {writeReg1, writeReg2}, ewr);
      chk({tag, " writeData"}, {writeData1, writeData2}, ewd);
    end
    @(negedge clk);
    chk({tag, " after wb"}, {write, done, in_ready}, 3'b001);
    chk({tag, " flags"}, {zero1, zero2, ovf1, ovf2}, eflags);
    chk({tag, " readReg idle"}, {readReg1, readReg2, readReg3, readReg4}, 16'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    resetn   = 1'b0;
    in_valid = 1'b0;
    pre_en   = 1'b0;
    pre_addr = '0;
    pre_data = '0;
    {op1, op2, dst1, dst2, srcA1, srcB1, srcA2, srcB2} = '0;
    for (int i = 0; i < 16; i++) init_rf[i] = '0;
    init_rf[1]  = 32'd5;
    init_rf[2]  = 32'd7;
    init_rf[3]  = 32'hFFFF_FFFF;
    init_rf[4]  = 32'd1;
    init_rf[5]  = 32'h1234;
    init_rf[10] = 32'h7FFF_FFFF;
    init_rf[11] = 32'h0001_0000;
    init_rf[12] = 32'h10;

    @(negedge clk);
    chk("reset in_ready", in_ready, 1);
    chk("reset write/done", {write, done}, 2'b00);
    chk("reset readReg", {readReg1, readReg2, readReg3, readReg4}, 16'h0);
    chk("reset writeReg", {writeReg1, writeReg2}, 8'h0);
    chk("reset writeData", {writeData1, writeData2}, 64'h0);
    chk("reset flags", {zero1, zero2, ovf1, ovf2}, 4'b0000);

    for (int i = 0; i < 16; i++) begin
      pre_en   = 1'b1;
      pre_addr = 4'(i);
      pre_data = init_rf[i];
      @(negedge clk);
    end
    pre_en = 1'b0;
    resetn = 1'b1;
    @(negedge clk);

    run("add/sub", 32'h0189_1234, 3, 1'b1, 8'h89, {32'd12, 32'hFFFF_FFFE}, 4'b0000);
    chk("add/sub r8", rf[8], 32'd12);
    chk("add/sub r9", rf[9], 32'hFFFF_FFFE);

    run("ovf/zero", 32'h01DE_A455, 3, 1'b1, 8'hDE, {32'h8000_0000, 32'h0}, 4'b0110);
    chk("ovf/zero r13", rf[13], 32'h8000_0000);

    run("mul+add", 32'hB0F9_BB1C, 35, 1'b1, 8'hF9, {32'h0, 32'h15}, 4'b1010);
    chk("mul+add r15", rf[15], 32'h0);
    chk("mul+add r9", rf[9], 32'h15);

    run("mul+mul", 32'hBBEF_1233, 35, 1'b1, 8'hEF, {32'h23, 32'h1}, 4'b0001);
    chk("mul+mul r14", rf[14], 32'h23);

    run("same dst", 32'h0366_44C4, 3, 1'b1, 8'h66, {32'h11, 32'h11}, 4'b0000);
    chk("same dst r6", rf[6], 32'h11);

    run("nop/xor", 32'hC437_1112, 3, 1'b1, 8'h77, {32'h2, 32'h2}, 4'b0000);
    chk("nop/xor r7", rf[7], 32'h2);
    chk("nop/xor r3 kept", rf[3], 32'hFFFF_FFFF);

    run("sub/nop", 32'h1E89_5512, 3, 1'b1, 8'h88, {32'h0, 32'h0}, 4'b1000);
    chk("sub/nop r9 kept", rf[9], 32'h15);

    for (int i = 0; i < 16; i++) snap[i] = rf[i];
    run("nop/nop", 32'hDF12_1234, 3, 1'b0, 8'h00, 64'h0, 4'b0000);
    chk("nop/nop rf diffs", rf_diffs(), 0);

    run("sra/slt", 32'h78EF_D434, 3, 1'b1, 8'hEF, {32'hC000_0000, 32'h1}, 4'b0000);
    run("sll/sltu", 32'h59EF_1334, 3, 1'b1, 8'hEF, {32'h8000_0000, 32'h0}, 4'b0100);
    run("srl/pass", 32'h6AEF_D4A0, 3, 1'b1, 8'hEF, {32'h4000_0000, 32'h7FFF_FFFF}, 4'b0000);
    run("and/subv", 32'h21EF_12D4, 3, 1'b1, 8'hEF, {32'h5, 32'h7FFF_FFFF}, 4'b0001);

    // Reset asserted in the second MUL cycle (cycle 4 after accept).
    for (int i = 0; i < 16; i++) snap[i] = rf[i];
    {op1, op2, dst1, dst2, srcA1, srcB1, srcA2, srcB2} = 32'hB012_BB11;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst busy", in_ready, 0);
    resetn = 1'b0;
    #1;
    chk("midrst write/done", {write, done}, 2'b00);
    chk("midrst in_ready", in_ready, 1);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("midrst rf diffs", rf_diffs(), 0);

    run("post-rst", 32'h0089_1244, 3, 1'b1, 8'h89, {32'd12, 32'd2}, 4'b0000);
    chk("post-rst r8", rf[8], 32'd12);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/dual_alu_wb.md
# dual_alu_wb

- Execute/write-back stage that sits directly downstream of `regfile`.
- Accepts one dual-lane command per handshake and drives all four `regfile` read ports. It computes two independent ALU results from the registered read data and writes both back through the two `regfile` write ports in a single write cycle.
- Multi-cycle multiply is supported per lane. Throughput is one command per 4 cycles, or 4+DATAWIDTH cycles when either lane multiplies.

## Interface
- DATAWIDTH, 32, operand/result width; must equal `regfile` DATAWIDTH, minimum 8.
- clk  in  1  rising-edge clock.
- resetn  in  1  asynchronous, active-low reset.
- in_valid  in  1  command valid.
- in_ready  out  1  high exactly when state == IDLE; high during reset.
- op1, op2  in  4 each  lane opcodes.
- dst1, dst2  in  4 each  destination registers.
- srcA1, srcB1, srcA2, srcB2  in  4 each  source registers.
- readReg1..readReg4  out  4 each  to `regfile`; carry srcA1, srcB1, srcA2, srcB2 respectively.
- readData1..readData4  in  DATAWIDTH each  from `regfile`; registered there, valid one cycle after address.
- writeReg1, writeReg2  out  4 each  to `regfile`.
- writeData1, writeData2  out  DATAWIDTH each  to `regfile`.
- write  out  1  to `regfile`; write strobe.
- done  out  1  one-cycle pulse, coincident with write cycle.
- zero1, zero2, ovf1, ovf2  out  1 each  lane flags; updated in the WB cycle and held until the next WB.

## Operation
- States: IDLE, READ, EXEC, MUL, WB.
- IDLE:
  - On in_valid & in_ready, capture all command fields into internal registers, then go to READ.
- READ:
  - readReg1..4 driven from the captured sources.
  - readReg outputs hold the captured values in every state except IDLE, where they are 0.
- EXEC:
  - readData is now valid. Latch A/B operands per lane.
  - If neither lane is MUL: compute both results and register them, then go to WB.
  - Otherwise load the multiplier state, clear the cycle counter, and go to MUL.
- MUL:
  - Shift-add, 1 bit per cycle. Both MUL lanes run in parallel on a shared counter.
  - A non-MUL lane's result is registered in EXEC and held.
  - Exit to WB when the counter reaches DATAWIDTH-1 (exactly DATAWIDTH cycles in MUL).
- WB: drive write, writeReg, writeData, and done for one cycle, update flags, then go to IDLE.
- Opcodes (results are DATAWIDTH bits and wrap):
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA: shift amount is B[$clog2(DATAWIDTH)-1:0].
  - 8 SLT (signed), 9 SLTU: result is 1 or 0.
  - 10 PASSA.
  - 11 MUL: low DATAWIDTH bits of unsigned A*B.
  - 12–15 NOP: the lane performs no write.
- ovfN:
  - Signed overflow for ADD/SUB.
  - For MUL, set if any upper product bit is nonzero.
  - 0 for all other opcodes.
- zeroN = (lane result == 0). For NOP lanes, the zero and ovf flags are 0.
- NOP handling: `regfile` has a single write strobe, so a NOP lane duplicates the other lane's writeReg/writeData.
- Both lanes NOP: write stays 0 in WB; done still pulses.
- dst1 == dst2, both lanes active: lane 2 wins. Drive writeData1 = writeData2 so the register content is deterministic.
- Outside WB: write = 0, and writeReg/writeData outputs hold their last WB values.
- No read/write overlap: write is only asserted in WB while no read is pending, so `regfile` bypass is never exercised.

## Timing
- Reset values: state IDLE, all readReg/writeReg 0, writeData 0, write 0, done 0, all flags 0. All outputs are registered except in_ready.
- Reset mid-operation:
  - Immediately returns to IDLE and the in-flight command is discarded.
  - write and done drop asynchronously, with no partial write.
- Timeline, with the accept at cycle 0:
  - Non-MUL command: READ cycle 1, EXEC cycle 2, WB cycle 3. Next accept no earlier than cycle 4.
  - MUL command: MUL cycles 3..DATAWIDTH+2, WB cycle DATAWIDTH+3.
- in_valid while busy is ignored. Command fields are don't-care outside the accept cycle.

## Test plan
- Reset, then preload `regfile`: r1=5, r2=7, r3=0xFFFFFFFF, r4=1. Command ADD r8=r1+r2, SUB r9=r3-r4. Required:
  - write=1 only in cycle 3.
  - r8=12, r9=0xFFFFFFFE.
  - zero1=zero2=0.
- ADD 0x7FFFFFFF+1 in lane 1 -> ovf1=1, result 0x80000000. SUB r5-r5 in lane 2 -> zero2=1.
- MUL 0x10000*0x10000 in lane 1 and ADD in lane 2 -> done at cycle 35 (DATAWIDTH=32). Required:
  - lane1 result 0, ovf1=1.
  - lane 2 result is correct.
  - in_ready stays low through cycle 35.
- dst1=dst2=r6, ADD 1+1 and OR 0x10|0x1 -> r6=0x11; writeData1=writeData2=0x11.
- Lane 1 NOP, lane 2 XOR into r7 -> both write ports target r7 with the same data. Both lanes NOP -> done=1, write=0, all registers unchanged.
- Assert resetn=0 in the second MUL cycle -> in the same cycle write=0 and in_ready=1; no register changes. The next command after release completes in 4 cycles.
